sap1_sequencer: RTL and testbench
=================================

// Module: sap1_sequencer
// PURPOSE
//   Microprogrammed control sequencer for the SAP-1 datapath. Runs a 6-state T-cycle ring (T1..T6).
//   Decodes the IR opcode into the 13-bit control word that drives bus arbitration, register loads, ALU mode and halt.
//   Sits between the IR opcode field and the clock gate / datapath enables.
// PARAMETERS
//   CW_W   13  control word width; bit map fixed (see BEHAVIOUR)
//   OP_W   4   opcode width
// PORTS
//   clk         in   1     system clock (gated clock from clock module)
//   rst         in   1     synchronous, active-high reset
//   opcode      in   4     IR[7:4]
//   step        in   1     single-step advance request (used only with SAP1_SINGLE_STEP_EN)
//   cw          out  13    control word
//   halt        out  1     halted status
//   t_state     out  6     one-hot T-state, bit0=T1 (0 while WAIT/HALTED)
//   instr_done  out  1     high during T6 of every instruction
// BEHAVIOUR
//   - One clock and synchronous active-high reset. All state updates on posedge clk.
//   - Control word bit map:
//     - [12]Ep PC->bus, [11]HLT, [10]Lm MAR load, [9]Cp PC inc, [8]CE RAM->bus, [7]Ei IR operand->bus
//     - [6]Li IR load, [5]La A load, [4]Ea A->bus, [3]Eu ALU->bus, [2]Su subtract, [1]Lb B load, [0]Lo OUT load
//   - cw, halt, t_state and instr_done are combinational from the registered state and opcode (Moore per T-state).
//     Datapath registers capture at the edge that ends the T-state.
//   - States: T1..T6 one-hot, plus HALTED (and WAIT when the macro is defined). Reset -> T1.
//     Reset outputs: cw=13'h1400, halt=0, t_state=6'b000001, instr_done=0.
//   - Fetch, opcode-independent:
//     - T1 = 13'h1400 (Ep|Lm)
//     - T2 = 13'h0200 (Cp)
//     - T3 = 13'h0140 (CE|Li)
//   - Execute; opcode is valid from T4 because IR loads at the end of T3:
//     - LDA 4'h0: T4=13'h0480 (Ei|Lm), T5=13'h0120 (CE|La), T6=0
//     - ADD 4'h1: T4=13'h0480, T5=13'h0102 (CE|Lb), T6=13'h0028 (Eu|La)
//     - SUB 4'h2: T4=13'h0480, T5=13'h0102, T6=13'h002C (Eu|Su|La)
//     - OUT 4'hE: T4=13'h0011 (Ea|Lo), T5=0, T6=0
//     - HLT 4'hF: T4=13'h0800
//     - Any other opcode: NOP, T4..T6 = 0
//   - Transitions: T1->...->T6->T1 with no early termination. Every instruction is exactly 6 cycles.
//   - Halt: in T4 with opcode 4'hF, halt and cw[11] assert combinationally in that same cycle, because the gated clock may never deliver another edge.
//     If an edge does arrive, the state moves to HALTED: cw=13'h0800, halt=1, t_state=0.
//     HALTED holds until rst.
//   - At most one bus driver is enabled in any state; this is guaranteed by the tables above.
//   - Reset mid-instruction: the next edge gives T1 and clears HALTED/WAIT; the partial instruction is abandoned.
//     Reset has priority over step and halt. Ungating the clock under rst is the clock module's responsibility.
//   - instr_done = 1 exactly in T6, and also in HLT T4/HALTED = 0.
// CONFIGURATION
//   SAP1_SINGLE_STEP_EN defined:
//     - T6 goes to WAIT instead of T1: cw=0, t_state=0, instr_done=0.
//     - WAIT -> T1 on the first edge with step=1. Step is level-sampled; holding step high runs continuously.
//     - step during T1..T6 is ignored.
//   SAP1_SINGLE_STEP_EN undefined: step is ignored, no WAIT state, and T6 goes directly to T1.
// STRUCTURE
//   - sap1_pkg holds: opcode localparams (OP_LDA/ADD/SUB/OUT/HLT), CW bit-index localparams,
//     the named control words (CW_FETCH_T1.., CW_HLT) and the state encoding.
//   - Sub-module sap1_ring_counter: one-hot T1..T6 ring with sync reset, an advance enable and a hold input.
//   - sap1_sequencer wraps the ring counter and adds the HALTED/WAIT flags and the decode case.
// TESTING
//   - rst high for 2 cycles, then low: cw sequence 1400,0200,0140; t_state 01,02,04; halt=0.
//   - opcode=0 (LDA) at T4..T6: cw 0480,0120,0000; instr_done=1 in T6 only; the next cycle is T1 (1400).
//   - ADD then SUB: T5=0102 for both; T6=0028 for ADD and 002C for SUB.
//   - opcode=F at T4: halt=1 and cw=0800 in the same cycle. After further edges: cw stays 0800, t_state=0.
//     rst then gives T1/1400, halt=0.
//   - Assert rst during ADD T5: the next cycle is T1 (1400); no 0028 word ever appears.
//   - With SAP1_SINGLE_STEP_EN: after T6, cw=0 with step=0 for 5 cycles. One cycle with step=1 gives T1 (1400) on the next cycle.

Source files
------------

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 sequencer shared constants
// Purpose: opcodes, control-word bit indices, named control words and the
//          one-hot T-state encoding shared by the sequencer and its ring counter.
// Ports:   none (package).
package sap1_pkg;

  localparam int CW_W = 13;
  localparam int OP_W = 4;

  // Opcodes (IR[7:4])
  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Control-word bit indices
  localparam int CW_B_EP  = 12;
  localparam int CW_B_HLT = 11;
  localparam int CW_B_LM  = 10;
  localparam int CW_B_CP  = 9;
  localparam int CW_B_CE  = 8;
  localparam int CW_B_EI  = 7;
  localparam int CW_B_LI  = 6;
  localparam int CW_B_LA  = 5;
  localparam int CW_B_EA  = 4;
  localparam int CW_B_EU  = 3;
  localparam int CW_B_SU  = 2;
  localparam int CW_B_LB  = 1;
  localparam int CW_B_LO  = 0;

  // Single-bit masks
  localparam logic [CW_W-1:0] CW_EP  = CW_W'(1) << CW_B_EP;
  localparam logic [CW_W-1:0] CW_HL  = CW_W'(1) << CW_B_HLT;
  localparam logic [CW_W-1:0] CW_LM  = CW_W'(1) << CW_B_LM;
  localparam logic [CW_W-1:0] CW_CP  = CW_W'(1) << CW_B_CP;
  localparam logic [CW_W-1:0] CW_CE  = CW_W'(1) << CW_B_CE;
  localparam logic [CW_W-1:0] CW_EI  = CW_W'(1) << CW_B_EI;
  localparam logic [CW_W-1:0] CW_LI  = CW_W'(1) << CW_B_LI;
  localparam logic [CW_W-1:0] CW_LA  = CW_W'(1) << CW_B_LA;
  localparam logic [CW_W-1:0] CW_EA  = CW_W'(1) << CW_B_EA;
  localparam logic [CW_W-1:0] CW_EU  = CW_W'(1) << CW_B_EU;
  localparam logic [CW_W-1:0] CW_SU  = CW_W'(1) << CW_B_SU;
  localparam logic [CW_W-1:0] CW_LB  = CW_W'(1) << CW_B_LB;
  localparam logic [CW_W-1:0] CW_LO  = CW_W'(1) << CW_B_LO;

  // Named control words
  localparam logic [CW_W-1:0] CW_NOP      = '0;
  localparam logic [CW_W-1:0] CW_FETCH_T1 = CW_EP | CW_LM;
  localparam logic [CW_W-1:0] CW_FETCH_T2 = CW_CP;
  localparam logic [CW_W-1:0] CW_FETCH_T3 = CW_CE | CW_LI;
  localparam logic [CW_W-1:0] CW_ADDR_T4  = CW_EI | CW_LM;
  localparam logic [CW_W-1:0] CW_LDA_T5   = CW_CE | CW_LA;
  localparam logic [CW_W-1:0] CW_ALU_T5   = CW_CE | CW_LB;
  localparam logic [CW_W-1:0] CW_ADD_T6   = CW_EU | CW_LA;
  localparam logic [CW_W-1:0] CW_SUB_T6   = CW_EU | CW_SU | CW_LA;
  localparam logic [CW_W-1:0] CW_OUT_T4   = CW_EA | CW_LO;
  localparam logic [CW_W-1:0] CW_HLT      = CW_HL;

  // One-hot T-state encoding (ST_NONE is shown while WAIT/HALTED)
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_T1   = 6'b000001;
  localparam logic [5:0] ST_T2   = 6'b000010;
  localparam logic [5:0] ST_T3   = 6'b000100;
  localparam logic [5:0] ST_T4   = 6'b001000;
  localparam logic [5:0] ST_T5   = 6'b010000;
  localparam logic [5:0] ST_T6   = 6'b100000;

endpackage

// File: rtl/sap1_sequencer_if.sv
// rtl/sap1_sequencer_if.sv - SAP-1 sequencer opcode/control bundle
// Purpose: groups the opcode/step inputs and control outputs of the sequencer.
// Signals: opcode (IR[7:4]), step (single-step request), cw (13-bit control
//          word), halt, t_state (one-hot, bit0=T1), instr_done.
// Modports: master = sequencer side, slave = IR/datapath/clock-gate side.
interface sap1_sequencer_if;
  import sap1_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            step;
  logic [CW_W-1:0] cw;
  logic            halt;
  logic [5:0]      t_state;
  logic            instr_done;

  modport master (
    input  opcode,
    input  step,
    output cw,
    output halt,
    output t_state,
    output instr_done
  );

  modport slave (
    output opcode,
    output step,
    input  cw,
    input  halt,
    input  t_state,
    input  instr_done
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - one-hot T1..T6 ring counter
// Purpose: six-state one-hot ring that rotates T1->T6->T1.
// Ports:
//   clk     in  1  clock
//   rst     in  1  synchronous active-high reset, forces T1
//   i_adv   in  1  rotate one position on this edge
//   i_hold  in  1  freeze the ring (overrides i_adv)
//   o_t     out 6  one-hot state, bit0=T1
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_adv,
  input  logic       i_hold,
  output logic [5:0] o_t
);

  logic [5:0] r_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= ST_T1;
    end else if (!i_hold && i_adv) begin
      r_t <= {r_t[4:0], r_t[5]};
    end
  end

  assign o_t = r_t;

endmodule

// File: rtl/sap1_sequencer.sv
// rtl/sap1_sequencer.sv - SAP-1 microprogrammed control sequencer
// Purpose: runs the T1..T6 ring and decodes (T-state, opcode) into the
//          13-bit control word; adds the HALTED flag and, with the
//          SAP1_SINGLE_STEP_EN macro defined, a WAIT state after T6 that is
//          left on the first edge with step=1.
// Ports:
//   clk  in  1  system (gated) clock
//   rst  in  1  synchronous active-high reset -> T1
//   bus  sap1_sequencer_if.master: opcode/step in; cw, halt, t_state,
//        instr_done out (all combinational from registered state + opcode)
module sap1_sequencer
  import sap1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sap1_sequencer_if.master    bus
);

  logic [5:0]      w_ring;
  logic            r_halted;
  logic            w_wait;
  logic            w_halt_now;
  logic [CW_W-1:0] w_cw;
  logic            w_halt;
  logic [5:0]      w_t_state;
  logic            w_instr_done;

  // HLT is recognised in T4 itself so halt reaches the clock gate before
  // the edge that might never come.
  assign w_halt_now = !r_halted && !w_wait && (w_ring == ST_T4) &&
                      (bus.opcode == OP_HLT);

  sap1_ring_counter u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (!w_wait),
    .i_hold (r_halted || w_halt_now),
    .o_t    (w_ring)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_halt_now) begin
      r_halted <= 1'b1;
    end
  end

`ifdef SAP1_SINGLE_STEP_EN
  logic r_wait;

  // The ring still rotates T6->T1 on entering WAIT, so leaving WAIT only
  // needs the flag cleared; the ring is frozen at T1 meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= 1'b0;
    end else if (r_wait) begin
      if (bus.step) begin
        r_wait <= 1'b0;
      end
    end else if (!r_halted && (w_ring == ST_T6)) begin
      r_wait <= 1'b1;
    end
  end

  assign w_wait = r_wait;
`else
  logic w_unused_step;
  assign w_unused_step = bus.step;
  assign w_wait        = 1'b0;
`endif

  always_comb begin
    w_cw         = CW_NOP;
    w_halt       = 1'b0;
    w_t_state    = ST_NONE;
    w_instr_done = 1'b0;
    if (r_halted) begin
      w_cw   = CW_HLT;
      w_halt = 1'b1;
    end else if (!w_wait) begin
      w_t_state = w_ring;
      case (w_ring)
        ST_T1: w_cw = CW_FETCH_T1;
        ST_T2: w_cw = CW_FETCH_T2;
        ST_T3: w_cw = CW_FETCH_T3;
        ST_T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: w_cw = CW_ADDR_T4;
            OP_OUT:                 w_cw = CW_OUT_T4;
            OP_HLT: begin
              w_cw   = CW_HLT;
              w_halt = 1'b1;
            end
            default:                w_cw = CW_NOP;
          endcase
        end
        ST_T5: begin
          case (bus.opcode)
            OP_LDA:         w_cw = CW_LDA_T5;
            OP_ADD, OP_SUB: w_cw = CW_ALU_T5;
            default:        w_cw = CW_NOP;
          endcase
        end
        ST_T6: begin
          w_instr_done = 1'b1;
          case (bus.opcode)
            OP_ADD:  w_cw = CW_ADD_T6;
            OP_SUB:  w_cw = CW_SUB_T6;
            default: w_cw = CW_NOP;
          endcase
        end
        default: w_cw = CW_NOP;
      endcase
    end
  end

  assign bus.cw         = w_cw;
  assign bus.halt       = w_halt;
  assign bus.t_state    = w_t_state;
  assign bus.instr_done = w_instr_done;

endmodule

// File: tb/tb_sap1_sequencer.sv
// tb/tb_sap1_sequencer.sv - scoreboard bench for sap1_sequencer
module tb_sap1_sequencer;

  typedef struct {
    int          id;
    logic [12:0] cw;
    logic        halt;
    logic [5:0]  t;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   n_cyc;
  exp_t q[$];

  sap1_sequencer_if bus();

  sap1_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are valid every cycle; compare mid-cycle on negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if (bus.cw !== e.cw || bus.halt !== e.halt ||
            bus.t_state !== e.t || bus.instr_done !== e.done) begin
          n_bad++;
          $display("FAIL cyc%0d: cw=%h halt=%b t=%b done=%b required cw=%h halt=%b t=%b done=%b",
                   e.id, bus.cw, bus.halt, bus.t_state, bus.instr_done,
                   e.cw, e.halt, e.t, e.done);
        end
      end
    end
  end

  // Drive inputs for one cycle and queue the outputs expected during it.
  task automatic cyc(input logic r, input logic [3:0] op, input logic st,
                     input logic [12:0] cw, input logic h, input logic [5:0] t,
                     input logic d);
    exp_t e;
    rst        = r;
    bus.opcode = op;
    bus.step   = st;
    e.id = n_cyc; e.cw = cw; e.halt = h; e.t = t; e.done = d;
    q.push_back(e);
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] exec_cw(input logic [3:0] op, input int t);
    logic [12:0] r;
    r = 13'h0000;
    case (op)
      4'h0: r = (t == 4) ? 13'h0480 : (t == 5) ? 13'h0120 : 13'h0000;
      4'h1: r = (t == 4) ? 13'h0480 : (t == 5) ? 13'h0102 : 13'h0028;
      4'h2: r = (t == 4) ? 13'h0480 : (t == 5) ? 13'h0102 : 13'h002C;
      4'hE: r = (t == 4) ? 13'h0011 : 13'h0000;
      default: r = 13'h0000;
    endcase
    return r;
  endfunction

  task automatic fetch(input logic [3:0] op);
    cyc(1'b0, op, 1'b0, 13'h1400, 1'b0, 6'b000001, 1'b0);
    cyc(1'b0, op, 1'b0, 13'h0200, 1'b0, 6'b000010, 1'b0);
    cyc(1'b0, op, 1'b0, 13'h0140, 1'b0, 6'b000100, 1'b0);
  endtask

  task automatic run_instr(input logic [3:0] op);
    fetch(op);
    cyc(1'b0, op, 1'b0, exec_cw(op, 4), 1'b0, 6'b001000, 1'b0);
    cyc(1'b0, op, 1'b0, exec_cw(op, 5), 1'b0, 6'b010000, 1'b0);
    cyc(1'b0, op, 1'b0, exec_cw(op, 6), 1'b0, 6'b100000, 1'b1);
`ifdef SAP1_SINGLE_STEP_EN
    for (int i = 0; i < 5; i++)
      cyc(1'b0, op, 1'b0, 13'h0000, 1'b0, 6'b000000, 1'b0);
    cyc(1'b0, op, 1'b1, 13'h0000, 1'b0, 6'b000000, 1'b0);
`endif
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    n_cyc   = 0;
    rst        = 1'b1;
    bus.opcode = 4'h0;
    bus.step   = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 4'h0, 1'b0, 13'h1400, 1'b0, 6'b000001, 1'b0);

    run_instr(4'h0);   // LDA
    run_instr(4'h1);   // ADD
    run_instr(4'h2);   // SUB
    run_instr(4'hE);   // OUT
    run_instr(4'h5);   // undefined -> NOP

    // Reset during ADD T5: the T6 ALU word must never appear.
    fetch(4'h1);
    cyc(1'b0, 4'h1, 1'b0, 13'h0480, 1'b0, 6'b001000, 1'b0);
    cyc(1'b1, 4'h1, 1'b0, 13'h0102, 1'b0, 6'b010000, 1'b0);
    run_instr(4'h1);

    // Halt: asserted combinationally in T4, then HALTED until reset.
    fetch(4'hF);
    cyc(1'b0, 4'hF, 1'b0, 13'h0800, 1'b1, 6'b001000, 1'b0);
    cyc(1'b0, 4'hF, 1'b1, 13'h0800, 1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 13'h0800, 1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 4'h1, 1'b1, 13'h0800, 1'b1, 6'b000000, 1'b0);
    cyc(1'b1, 4'hF, 1'b0, 13'h0800, 1'b1, 6'b000000, 1'b0);
    run_instr(4'h2);

    @(negedge clk);
    #1;
    n_total++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
